wb_arbiter2: RTL and testbench

- Two-master, one-slave Wishbone (classic, single-cycle ack) arbiter for the lm32 SoC.
- Shares the system bus between the lm32 instruction bus (m0) and data bus (m1), ahead of the address decoder.
- Fair round-robin grant, held for the whole cycle (cyc high), so block and locked transfers stay atomic.
- A watchdog terminates transfers the slave never acknowledges, so a dead peripheral cannot hang the CPU.

---
 rtl/wb_arbiter2_if.sv | 17 +
 rtl/wb_arbiter2.sv | 69 ++++++
 tb/tb_wb_arbiter2.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter2_if.sv
// wb_arbiter2_if: one Wishbone classic port (cycle, strobe, address/data, ack/err).
interface wb_arbiter2_if #(
    parameter int adr_width = 32,
    parameter int dat_width = 32
);
    logic                   cyc;
    logic                   stb;
    logic                   we;
    logic [adr_width-1:0]   adr;
    logic [dat_width-1:0]   dat_w;
    logic [dat_width/8-1:0] sel;
    logic [dat_width-1:0]   dat_r;
    logic                   ack;
    logic                   err;
    modport master (output cyc, stb, we, adr, dat_w, sel, input dat_r, ack, err);
    modport slave  (input cyc, stb, we, adr, dat_w, sel, output dat_r, ack, err);
endinterface

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master round-robin Wishbone classic arbiter with ack watchdog.
module wb_arbiter2 #(
    parameter int adr_width      = 32,
    parameter int dat_width      = 32,
    parameter int timeout_cycles = 255
) (
    input  logic          clk,
    input  logic          rst,
    wb_arbiter2_if.slave  m0,
    wb_arbiter2_if.slave  m1,
    wb_arbiter2_if.master s,
    output logic [1:0]    grant
);
    localparam int cw = timeout_cycles > 0 ? $clog2(timeout_cycles + 1) : 1;
    localparam int sw = dat_width / 8;
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    state_t        state, state_nx;
    logic          last_m1, last_m1_nx;
    logic [1:0]    grant_q;
    logic [cw-1:0] wd_cnt;
    logic          wd_err, wd_clr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            last_m1 <= 1'b1;
            grant_q <= 2'b00;
            wd_cnt  <= '0;
        end else begin
            state   <= state_nx;
            last_m1 <= last_m1_nx;
            grant_q <= grant;
            wd_cnt  <= wd_clr ? '0 : wd_cnt + cw'(1);
        end
    end
    always_comb begin
        state_nx   = state;
        last_m1_nx = last_m1;
        case (state)
            IDLE: state_nx = (m0.cyc && (!m1.cyc || last_m1)) ? GNT0 : m1.cyc ? GNT1 : IDLE;
            GNT0: if (!m0.cyc) begin
                state_nx   = m1.cyc ? GNT1 : IDLE;
                last_m1_nx = 1'b0;
            end
            GNT1: if (!m1.cyc) begin
                state_nx   = m0.cyc ? GNT0 : IDLE;
                last_m1_nx = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end
    // Bus mux follows the registered grant; a zero grant parks the slave side at all-zero.
    always_comb begin
        grant   = {state == GNT1, state == GNT0};
        s.cyc   = grant[0] ? m0.cyc : grant[1] & m1.cyc;
        s.stb   = grant[0] ? m0.stb : grant[1] & m1.stb;
        s.we    = grant[0] ? m0.we  : grant[1] & m1.we;
        s.adr   = grant[0] ? m0.adr   : grant[1] ? m1.adr   : adr_width'(0);
        s.dat_w = grant[0] ? m0.dat_w : grant[1] ? m1.dat_w : dat_width'(0);
        s.sel   = grant[0] ? m0.sel   : grant[1] ? m1.sel   : sw'(0);
        wd_err  = timeout_cycles != 0 && wd_cnt == cw'(timeout_cycles);
        wd_clr  = timeout_cycles == 0 || s.ack || s.err || !(s.cyc && s.stb) || grant != grant_q || wd_err;
        m0.dat_r = s.dat_r;
        m1.dat_r = s.dat_r;
        m0.ack  = s.ack & grant[0];
        m1.ack  = s.ack & grant[1];
        m0.err  = (s.err | (wd_err & ~s.ack)) & grant[0];
        m1.err  = (s.err | (wd_err & ~s.ack)) & grant[1];
    end
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed and randomized checks of arbitration, muxing, watchdog and reset.
module tb_wb_arbiter2;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] grant;
    int         checks = 0;
    int         errors = 0;
    always #5 clk = ~clk;
    wb_arbiter2_if #(.adr_width(32), .dat_width(32)) m0_if ();
    wb_arbiter2_if #(.adr_width(32), .dat_width(32)) m1_if ();
    wb_arbiter2_if #(.adr_width(32), .dat_width(32)) s_if ();
    wb_arbiter2 #(.adr_width(32), .dat_width(32), .timeout_cycles(16)) dut (
        .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if), .s(s_if), .grant(grant)
    );
    task automatic idle_inputs;
        m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; m0_if.adr = 0; m0_if.dat_w = 0; m0_if.sel = 0;
        m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0; m1_if.adr = 0; m1_if.dat_w = 0; m1_if.sel = 0;
        s_if.dat_r = 0; s_if.ack = 0; s_if.err = 0;
    endtask
    task automatic apply_reset;
        idle_inputs();
        rst = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
    endtask
    task automatic nxt;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        idle_inputs();
        rst = 0;
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h1000_0040;
        m1_if.cyc = 1; m1_if.stb = 1; m1_if.adr = 32'h2000_0080;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks += 2;
            if (s_if.cyc !== 1'b0) begin errors++; $display("FAIL reset_s_cyc cycle %0d got %b want 0", i, s_if.cyc); end
            if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant cycle %0d got %b want 00", i, grant); end
        end
        rst = 1;
        nxt();
        @(negedge clk);
        checks += 2;
        if (grant !== 2'b01) begin errors++; $display("FAIL release_grant got %b want 01", grant); end
        if (s_if.adr !== 32'h1000_0040) begin errors++; $display("FAIL release_adr got %h want 10000040", s_if.adr); end
        idle_inputs();
    endtask
    task automatic test_contention;
        int done0 = 0, done1 = 0;
        bit drop0 = 0, drop1 = 0, prev_stb = 0, prev_ack = 0, started = 0, gap = 0;
        logic [1:0] seq[$];
        logic [1:0] last_g = 2'b00;
        apply_reset();
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h100;
        m1_if.cyc = 1; m1_if.stb = 1; m1_if.adr = 32'h200;
        for (int c = 0; c < 60 && (done0 + done1) < 6; c++) begin
            nxt();
            s_if.ack = prev_stb && !prev_ack;
            if (drop0) begin m0_if.cyc = 0; m0_if.stb = 0; drop0 = 0; end
            else begin m0_if.cyc = done0 < 3; m0_if.stb = done0 < 3; end
            if (drop1) begin m1_if.cyc = 0; m1_if.stb = 0; drop1 = 0; end
            else begin m1_if.cyc = done1 < 3; m1_if.stb = done1 < 3; end
            @(negedge clk);
            if (grant != 2'b00 && grant != last_g) begin seq.push_back(grant); last_g = grant; end
            if (grant != 2'b00) started = 1;
            if (started && grant == 2'b00) gap = 1;
            checks++;
            if ((m0_if.ack && !grant[0]) || (m1_if.ack && !grant[1])) begin
                errors++; $display("FAIL contention_nonowner_ack acks %b%b grant %b", m1_if.ack, m0_if.ack, grant);
            end
            if (m0_if.ack) begin done0++; drop0 = 1; end
            if (m1_if.ack) begin done1++; drop1 = 1; end
            prev_stb = s_if.stb;
            prev_ack = s_if.ack;
        end
        checks += 4;
        if (done0 != 3) begin errors++; $display("FAIL contention_acks_m0 got %0d want 3", done0); end
        if (done1 != 3) begin errors++; $display("FAIL contention_acks_m1 got %0d want 3", done1); end
        if (gap) begin errors++; $display("FAIL contention_idle_gap got idle cycle want none"); end
        if (seq.size() != 6) begin errors++; $display("FAIL contention_seq_len got %0d want 6", seq.size()); end
        for (int i = 0; i < seq.size() && i < 6; i++) begin
            checks++;
            if (seq[i] !== ((i % 2) ? 2'b10 : 2'b01))
                begin errors++; $display("FAIL contention_seq[%0d] got %b want %b", i, seq[i], (i % 2) ? 2'b10 : 2'b01); end
        end
        nxt();
        idle_inputs();
    endtask
    task automatic test_block_hold;
        int acks1 = 0;
        apply_reset();
        m1_if.cyc = 1; m1_if.adr = 32'h400;
        for (int c = 1; c <= 9; c++) begin
            nxt();
            m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h500;
            m1_if.cyc = c <= 7;
            m1_if.stb = c <= 7 && (c % 2) == 1;
            s_if.ack = m1_if.stb;
            @(negedge clk);
            checks += 2;
            if (grant !== ((c <= 8) ? 2'b10 : 2'b01))
                begin errors++; $display("FAIL block_grant cycle %0d got %b want %b", c, grant, (c <= 8) ? 2'b10 : 2'b01); end
            if (m0_if.ack !== 1'b0) begin errors++; $display("FAIL block_m0_ack cycle %0d got %b want 0", c, m0_if.ack); end
            if (m1_if.ack) acks1++;
        end
        checks++;
        if (acks1 != 4) begin errors++; $display("FAIL block_m1_acks got %0d want 4", acks1); end
        idle_inputs();
    endtask
    task automatic test_watchdog(input bit race);
        apply_reset();
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'hF000_0000;
        for (int c = 1; c <= 30; c++) begin
            nxt();
            s_if.ack = race && c == 18;
            @(negedge clk);
            checks += 3;
            if (m0_if.err !== (!race && c == 18))
                begin errors++; $display("FAIL wd_m0_err race %0d cycle %0d got %b want %b", race, c, m0_if.err, !race && c == 18); end
            if (m0_if.ack !== (race && c == 18))
                begin errors++; $display("FAIL wd_m0_ack race %0d cycle %0d got %b want %b", race, c, m0_if.ack, race && c == 18); end
            if (m1_if.err !== 1'b0) begin errors++; $display("FAIL wd_m1_err cycle %0d got %b want 0", c, m1_if.err); end
        end
        idle_inputs();
    endtask
    task automatic test_async_reset;
        apply_reset();
        m1_if.cyc = 1; m1_if.stb = 1; m1_if.we = 1; m1_if.adr = 32'h3000_0000;
        m1_if.dat_w = 32'hDEAD_BEEF; m1_if.sel = 4'hF;
        nxt();
        @(negedge clk);
        checks += 3;
        if (grant !== 2'b10) begin errors++; $display("FAIL wr_grant got %b want 10", grant); end
        if (s_if.dat_w !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_dat got %h want deadbeef", s_if.dat_w); end
        if (s_if.we !== 1'b1) begin errors++; $display("FAIL wr_we got %b want 1", s_if.we); end
        nxt();
        #2 rst = 0;
        #1;
        checks += 2;
        if (s_if.cyc !== 1'b0) begin errors++; $display("FAIL async_s_cyc got %b want 0", s_if.cyc); end
        if (grant !== 2'b00) begin errors++; $display("FAIL async_grant got %b want 00", grant); end
        s_if.ack = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (m1_if.ack !== 1'b0) begin errors++; $display("FAIL async_m1_ack step %0d got %b want 0", i, m1_if.ack); end
            @(negedge clk);
        end
        rst = 1;
        idle_inputs();
    endtask
    task automatic test_random;
        int owner = 0, last = 2;
        logic [1:0]  exp_g;
        logic        exp_cyc;
        logic [31:0] exp_adr;
        logic [3:0]  exp_ae;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            if (owner == 0) owner = (m0_if.cyc && m1_if.cyc) ? (last == 2 ? 1 : 2) : m0_if.cyc ? 1 : m1_if.cyc ? 2 : 0;
            else if (owner == 1 && !m0_if.cyc) begin last = 1; owner = m1_if.cyc ? 2 : 0; end
            else if (owner == 2 && !m1_if.cyc) begin last = 2; owner = m0_if.cyc ? 1 : 0; end
            nxt();
            m0_if.cyc = m0_if.cyc ? $urandom_range(0, 3) != 0 : $urandom_range(0, 2) == 0;
            m1_if.cyc = m1_if.cyc ? $urandom_range(0, 3) != 0 : $urandom_range(0, 2) == 0;
            m0_if.stb = m0_if.cyc & 1'($urandom_range(0, 1));
            m1_if.stb = m1_if.cyc & 1'($urandom_range(0, 1));
            m0_if.adr = $urandom; m1_if.adr = $urandom;
            m0_if.we = 1'($urandom); m1_if.we = 1'($urandom);
            m0_if.dat_w = $urandom; m1_if.dat_w = $urandom;
            m0_if.sel = 4'($urandom); m1_if.sel = 4'($urandom);
            s_if.ack = 1'($urandom_range(0, 1));
            s_if.err = !s_if.ack && $urandom_range(0, 7) == 0;
            s_if.dat_r = $urandom;
            @(negedge clk);
            exp_g   = owner == 1 ? 2'b01 : owner == 2 ? 2'b10 : 2'b00;
            exp_cyc = owner == 1 ? m0_if.cyc : owner == 2 ? m1_if.cyc : 1'b0;
            exp_adr = owner == 1 ? m0_if.adr : owner == 2 ? m1_if.adr : 32'h0;
            exp_ae  = {s_if.ack && owner == 2, s_if.err && owner == 2, s_if.ack && owner == 1, s_if.err && owner == 1};
            checks += 5;
            if (grant !== exp_g) begin errors++; $display("FAIL rand_grant step %0d got %b want %b", n, grant, exp_g); end
            if (s_if.cyc !== exp_cyc) begin errors++; $display("FAIL rand_s_cyc step %0d got %b want %b", n, s_if.cyc, exp_cyc); end
            if (s_if.adr !== exp_adr) begin errors++; $display("FAIL rand_s_adr step %0d got %h want %h", n, s_if.adr, exp_adr); end
            if ({m1_if.ack, m1_if.err, m0_if.ack, m0_if.err} !== exp_ae)
                begin errors++; $display("FAIL rand_ack_err step %0d got %b want %b", n, {m1_if.ack, m1_if.err, m0_if.ack, m0_if.err}, exp_ae); end
            if (m1_if.dat_r !== s_if.dat_r) begin errors++; $display("FAIL rand_dat_r step %0d got %h want %h", n, m1_if.dat_r, s_if.dat_r); end
        end
        idle_inputs();
    endtask
    initial begin
        test_reset();
        test_contention();
        test_block_hold();
        test_watchdog(1'b0);
        test_watchdog(1'b1);
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
